// File: rtl/sram_ecc_secded_decoder_pkg.sv
// Shared ECC helpers for the SRAM read path: code-width derivation,
// data-bit to codeword-position mapping and the decode status type.
package hydra_ecc_pkg;

  typedef enum logic [1:0] {
    ECC_CLEAN = 2'd0,
    ECC_SEC   = 2'd1,
    ECC_DED   = 2'd2
  } ecc_status_e;

  // Smallest k with 2^k >= data_w + k + 1.
  function automatic int ecc_k(input int data_w);
    int k;
    k = 0;
    for (int j = 1; j < 30; j++) begin
      if ((k == 0) && ((1 << j) >= (data_w + j + 1))) begin
        k = j;
      end
    end
    return k;
  endfunction

  function automatic int ecc_code_w(input int data_w);
    return ecc_k(data_w) + 1;
  endfunction

  // Codeword position of data bit i: skip every power-of-2 slot at or below it.
  function automatic int data_pos(input int i);
    int pos;
    pos = i + 1;
    for (int j = 0; j < 30; j++) begin
      if ((1 << j) <= pos) begin
        pos = pos + 1;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/sram_ecc_syndrome_gen.sv
// Combinational Hamming check-bit and data-parity generator; shared by the
// SECDED encoder and decoder.
module sram_ecc_syndrome_gen
  import hydra_ecc_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int K      = ecc_k(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  output logic [K-1:0]      ham,
  output logic              data_par
);

  logic [K-1:0] pos_mask [DATA_W];

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pos
    localparam int POS = data_pos(gi);
    assign pos_mask[gi] = K'(POS);
  end

  // Each data bit contributes to every Hamming bit selected by its position.
  always_comb begin
    ham = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ham = ham ^ (pos_mask[i] & {K{data[i]}});
    end
  end

  assign data_par = ^data;

endmodule

// File: rtl/sram_ecc_secded_decoder.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready handshake and
// saturating SEC/DED event counters.
module sram_ecc_secded_decoder
  import hydra_ecc_pkg::*;
#(
  parameter  int WORD_W = 16,
  parameter  int WORDS  = 8,
  parameter  int CNT_W  = 16,
  localparam int DATA_W = WORD_W * WORDS,
  localparam int CODE_W = ecc_code_w(WORD_W * WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CODE_W-1:0] in_code,
  input  logic              bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt,
  input  logic              cnt_clr
);

  localparam int K = CODE_W - 1;
  localparam int N = DATA_W + K;

  logic [K-1:0]      ham_s;
  logic              data_par_s;
  logic              s1_en_s, s2_en_s, xfer_s;
  logic [DATA_W-1:0] flip_s, fixed_s;
  ecc_status_e       status_s;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [K-1:0]      s1_syn_q, s1_syn_d;
  logic              s1_par_q, s1_par_d;
  logic              s1_bypass_q, s1_bypass_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sec_q, out_sec_d;
  logic              out_ded_q, out_ded_d;
  logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;

  sram_ecc_syndrome_gen #(
    .DATA_W (DATA_W),
    .K      (K)
  ) u_gen (
    .data     (in_data),
    .ham      (ham_s),
    .data_par (data_par_s)
  );

  assign s2_en_s  = !out_valid_q || out_ready;
  assign s1_en_s  = !s1_valid_q || s2_en_s;
  assign in_ready = s1_en_s;
  assign xfer_s   = out_valid_q && out_ready;

  // S1 next state: capture the beat with its syndrome and overall parity.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_syn_d    = s1_syn_q;
    s1_par_d    = s1_par_q;
    s1_bypass_d = s1_bypass_q;
    if (s1_en_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d   = in_data;
        s1_syn_d    = ham_s ^ in_code[K-1:0];
        s1_par_d    = data_par_s ^ (^in_code);
        s1_bypass_d = bypass;
      end else begin
        s1_data_d = s1_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // One-hot flip vector: only a syndrome naming a data position selects a bit.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_flip
    localparam int POS = data_pos(gi);
    assign flip_s[gi] = (s1_syn_q == K'(POS));
  end

  // Classify the S1 beat and build the corrected word.
  always_comb begin
    status_s = ECC_CLEAN;
    fixed_s  = s1_data_q;
    if (s1_bypass_q) begin
      status_s = ECC_CLEAN;
    end else if (!s1_par_q) begin
      status_s = (s1_syn_q == '0) ? ECC_CLEAN : ECC_DED;
    end else if (s1_syn_q > K'(N)) begin
      status_s = ECC_DED;
    end else begin
      status_s = ECC_SEC;
      fixed_s  = s1_data_q ^ flip_s;
    end
  end

  // S2 next state: outputs only move when downstream can take a new beat.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sec_d   = out_sec_q;
    out_ded_d   = out_ded_q;
    if (s2_en_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = fixed_s;
        case (status_s)
          ECC_SEC: begin out_sec_d = 1'b1; out_ded_d = 1'b0; end
          ECC_DED: begin out_sec_d = 1'b0; out_ded_d = 1'b1; end
          default: begin out_sec_d = 1'b0; out_ded_d = 1'b0; end
        endcase
      end else begin
        out_sec_d = 1'b0;
        out_ded_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Counters: clear wins over an increment; saturate at all-ones.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (cnt_clr) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else begin
      if (xfer_s && out_sec_q && (sec_cnt_q != {CNT_W{1'b1}})) begin
        sec_cnt_d = sec_cnt_q + CNT_W'(1);
      end else begin
        sec_cnt_d = sec_cnt_q;
      end
      if (xfer_s && out_ded_q && (ded_cnt_q != {CNT_W{1'b1}})) begin
        ded_cnt_d = ded_cnt_q + CNT_W'(1);
      end else begin
        ded_cnt_d = ded_cnt_q;
      end
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_syn_q    <= '0;
      s1_par_q    <= 1'b0;
      s1_bypass_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sec_q   <= 1'b0;
      out_ded_q   <= 1'b0;
      sec_cnt_q   <= '0;
      ded_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_syn_q    <= s1_syn_d;
      s1_par_q    <= s1_par_d;
      s1_bypass_q <= s1_bypass_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sec_q   <= out_sec_d;
      out_ded_q   <= out_ded_d;
      sec_cnt_q   <= sec_cnt_d;
      ded_cnt_q   <= ded_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sec   = out_sec_q;
  assign out_ded   = out_ded_q;
  assign sec_cnt   = sec_cnt_q;
  assign ded_cnt   = ded_cnt_q;

endmodule

// File: tb/tb_sram_ecc_secded_decoder.sv
// Self-checking bench: injected-error beats scored against a queue of
// expected results plus a saturating counter model.
module tb_sram_ecc_secded_decoder;

  localparam int DW   = 128;
  localparam int CW   = 9;
  localparam int NPOS = 136;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, bypass = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic          in_ready, out_valid, out_sec, out_ded;
  logic [DW-1:0] in_data = '0, out_data;
  logic [CW-1:0] in_code = '0;
  logic [15:0]   sec_cnt, ded_cnt;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sec;
    logic          ded;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [15:0] m_sec = 16'd0, m_ded = 16'd0;
  logic        stall_seen = 1'b0;
  exp_t        held;

  sram_ecc_secded_decoder #(.WORD_W(16), .WORDS(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_code(in_code), .bypass(bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sec(out_sec), .out_ded(out_ded), .sec_cnt(sec_cnt),
    .ded_cnt(ded_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  // Golden code: lay data into codeword positions, then XOR by position bit.
  function automatic logic [CW-1:0] golden(input logic [DW-1:0] d);
    logic [NPOS:0] cw;
    logic [7:0]    ham;
    int            i;
    cw = '0; ham = '0; i = 0;
    for (int p = 1; p <= NPOS; p++)
      if ((p & (p - 1)) != 0) begin cw[p] = d[i]; i++; end
    for (int j = 0; j < 8; j++)
      for (int p = 1; p <= NPOS; p++)
        if (((p >> j) & 1) == 1) ham[j] = ham[j] ^ cw[p];
    return {(^d) ^ (^ham), ham};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // kind: 0 clean, 1 data flip, 2 code flip, 3 double, 4 bypass+flip, 5 triple (syn > N)
  task automatic mk(input int kind, input logic [DW-1:0] d, input int b0, input int b1,
                    output logic [DW-1:0] raw, output logic [CW-1:0] c,
                    output logic byp, output exp_t e);
    c = golden(d); raw = d; byp = 1'b0;
    e.data = d; e.sec = 1'b0; e.ded = 1'b0;
    case (kind)
      1: begin raw[b0] = ~raw[b0]; e.sec = 1'b1; end
      2: begin c[b0] = ~c[b0]; e.sec = 1'b1; end
      3: begin raw[b0] = ~raw[b0]; raw[b1] = ~raw[b1]; e.data = raw; e.ded = 1'b1; end
      4: begin raw[b0] = ~raw[b0]; byp = 1'b1; e.data = raw; end
      5: begin raw[0] = ~raw[0]; raw[1] = ~raw[1]; raw[127] = ~raw[127]; e.data = raw; e.ded = 1'b1; end
      default: ;
    endcase
  endtask

  // One clock, entered just after a falling edge; scores what transfers at the next rise.
  task automatic tick(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic byp, input logic ordy, input logic clr,
                      input exp_t e, output logic acc);
    exp_t f;
    in_valid = iv; in_data = d; in_code = c; bypass = byp; out_ready = ordy; cnt_clr = clr;
    #1;
    acc = iv & in_ready;
    if (stall_seen) begin
      chk("hold_data", out_data, held.data);
      chk("hold_flags", {out_valid, out_sec, out_ded}, {1'b1, held.sec, held.ded});
    end
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", out_valid, 1'b0);
      end else begin
        f = exp_q.pop_front();
        chk("data", out_data, f.data);
        chk("flags", {out_sec, out_ded}, {f.sec, f.ded});
        if (f.sec && m_sec != 16'hFFFF) m_sec++;
        if (f.ded && m_ded != 16'hFFFF) m_ded++;
      end
    end
    if (clr) begin m_sec = 16'd0; m_ded = 16'd0; end
    stall_seen = out_valid && !ordy;
    held.data = out_data; held.sec = out_sec; held.ded = out_ded;
    if (acc) exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic byp,
                      input exp_t e, input bit rnd);
    logic acc;
    int   tries;
    acc = 1'b0; tries = 0;
    while (!acc && tries < 64) begin
      tick(1'b1, d, c, byp, rnd ? ($urandom_range(0, 9) < 7) : 1'b1, 1'b0, e, acc);
      tries++;
    end
    n_cmp++;
    assert (acc === 1'b1) else begin
      n_mis++;
      $error("FAIL accept_timeout: observed %0b expected 1", acc);
    end
  endtask

  task automatic drain();
    logic acc;
    exp_t e0;
    int   tries;
    e0 = '0; tries = 0;
    while (exp_q.size() > 0 && tries < 200) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, e0, acc);
      tries++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_sec_cnt"}, sec_cnt, m_sec);
    chk({tag, "_ded_cnt"}, ded_cnt, m_ded);
  endtask

  initial begin
    logic [DW-1:0] dd, raw;
    logic [CW-1:0] c;
    logic          byp, acc;
    exp_t          e, e0;
    logic [DW-1:0] braw [4];
    logic [CW-1:0] bc [4];
    exp_t          be [4];
    int            idx, kind, b0, b1;

    e0 = '0;
    dd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_flags", {out_sec, out_ded}, 2'b00);
    chk_cnt("rst");
    rst = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1'b1);

    // Clean beat with latency check
    mk(0, dd, 0, 0, raw, c, byp, e);
    send(raw, c, byp, e, 1'b0);
    chk("lat_cycle1", out_valid, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, e0, acc);
    chk("lat_cycle2", out_valid, 1'b1);
    drain();
    chk_cnt("clean");

    // Single data flips, check-bit flips, double, triple, bypass
    mk(1, dd, 77, 0, raw, c, byp, e);  send(raw, c, byp, e, 1'b0); drain(); chk_cnt("sec77");
    mk(1, dd, 0, 0, raw, c, byp, e);   send(raw, c, byp, e, 1'b0); drain();
    mk(1, dd, 127, 0, raw, c, byp, e); send(raw, c, byp, e, 1'b0); drain(); chk_cnt("sec_edges");
    mk(2, dd, 3, 0, raw, c, byp, e);   send(raw, c, byp, e, 1'b0); drain();
    mk(2, dd, 8, 0, raw, c, byp, e);   send(raw, c, byp, e, 1'b0); drain(); chk_cnt("code_flip");
    mk(3, dd, 5, 90, raw, c, byp, e);  send(raw, c, byp, e, 1'b0); drain(); chk_cnt("ded");
    mk(5, dd, 0, 0, raw, c, byp, e);   send(raw, c, byp, e, 1'b0); drain(); chk_cnt("triple");
    mk(4, dd, 40, 0, raw, c, byp, e);  send(raw, c, byp, e, 1'b0); drain(); chk_cnt("bypass");

    // Backpressure: out_ready low for the first cycles, 4 back-to-back beats
    for (int i = 0; i < 4; i++) begin
      mk(i % 2, {$urandom(), $urandom(), $urandom(), $urandom()}, 13 + i * 29, 0,
         braw[i], bc[i], byp, be[i]);
    end
    idx = 0;
    for (int cyc = 0; cyc < 40 && (idx < 4 || exp_q.size() > 0); cyc++) begin
      tick(idx < 4, braw[idx < 4 ? idx : 0], bc[idx < 4 ? idx : 0], 1'b0, cyc >= 4, 1'b0,
           be[idx < 4 ? idx : 0], acc);
      if (acc) idx++;
      if (cyc == 2) begin
        chk("bp_in_ready", acc, 1'b0);
        chk("bp_accepted", idx, 2);
      end
    end
    chk("bp_all_sent", idx, 4);
    drain();
    chk_cnt("bp");

    // Randomised mix with random gaps and random out_ready
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 5);
      b0 = (kind == 2) ? $urandom_range(0, 8) : $urandom_range(0, 127);
      b1 = (b0 + 1 + $urandom_range(0, 126)) % 128;
      mk(kind, {$urandom(), $urandom(), $urandom(), $urandom()}, b0, b1, raw, c, byp, e);
      if ($urandom_range(0, 3) == 0) tick(1'b0, '0, '0, 1'b0, $urandom_range(0, 1), 1'b0, e0, acc);
      send(raw, c, byp, e, 1'b1);
    end
    drain();
    chk_cnt("random");

    // Saturation of sec_cnt
    tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, e0, acc);
    chk_cnt("clr");
    mk(1, dd, 64, 0, raw, c, byp, e);
    for (int n = 0; n < 65535; n++) send(raw, c, byp, e, 1'b0);
    drain();
    chk("sat_reach", sec_cnt, 16'hFFFF);
    send(raw, c, byp, e, 1'b0);
    drain();
    chk("sat_hold", sec_cnt, 16'hFFFF);
    chk_cnt("sat");

    // Clear coincident with an SEC transfer
    send(raw, c, byp, e, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, e0, acc);
    tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, e0, acc);
    tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, e0, acc);
    chk("clr_vs_inc", sec_cnt, 16'd0);
    chk_cnt("clr_inc");

    // Reset while stalled
    mk(3, dd, 5, 90, raw, c, byp, e);
    send(raw, c, byp, e, 1'b0);
    send(raw, c, byp, e, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, e0, acc);
    chk("stall_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_stall_valid", out_valid, 1'b0);
    chk("rst_stall_data", out_data, '0);
    chk("rst_stall_cnt", ded_cnt, 16'd0);
    exp_q.delete();
    m_sec = 16'd0; m_ded = 16'd0; stall_seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_rel_in_ready", in_ready, 1'b1);
    mk(1, dd, 100, 0, raw, c, byp, e);
    send(raw, c, byp, e, 1'b0);
    drain();
    chk_cnt("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
